// File: rtl/zeroheti_pkg.sv
// Shared interconnect types: address rule, default two-region map, demux port index.
package zeroheti_pkg;

    localparam int unsigned AddrW         = 32;
    localparam int unsigned DemuxNumRules = 2;

    typedef struct packed {
        logic [AddrW-1:0] base;  // inclusive
        logic [AddrW-1:0] last;  // exclusive
    } addr_rule_t;

    // One extra code point so the optional internal error responder has an index.
    typedef logic [$clog2(DemuxNumRules+1)-1:0] demux_idx_t;

    localparam addr_rule_t [DemuxNumRules-1:0] AddrMap = '{
        '{base: 32'h0000_9000, last: 32'h0000_A000},
        '{base: 32'h0000_0000, last: 32'h0000_1000}
    };

endpackage

// File: rtl/zeroheti_addr_demux_if.sv
// Initiator-side and target-side bus of the address demux; slave = demux view.
interface zeroheti_addr_demux_if #(
    parameter int unsigned NumRules  = 2,
    parameter int unsigned AddrWidth = 32,
    parameter int unsigned DataWidth = 32
);
    logic                               ini_req_i;
    logic                               ini_gnt_o;
    logic [AddrWidth-1:0]               ini_addr_i;
    logic                               ini_we_i;
    logic [DataWidth/8-1:0]             ini_be_i;
    logic [DataWidth-1:0]               ini_wdata_i;
    logic                               ini_rvalid_o;
    logic [DataWidth-1:0]               ini_rdata_o;
    logic                               ini_err_o;

    logic [NumRules-1:0]                tgt_req_o;
    logic [NumRules-1:0]                tgt_gnt_i;
    logic [NumRules-1:0]                tgt_rvalid_i;
    logic [NumRules-1:0][DataWidth-1:0] tgt_rdata_i;
    logic [NumRules-1:0]                tgt_err_i;
    logic [AddrWidth-1:0]               tgt_addr_o;
    logic                               tgt_we_o;
    logic [DataWidth/8-1:0]             tgt_be_o;
    logic [DataWidth-1:0]               tgt_wdata_o;

    modport slave (
        input  ini_req_i, ini_addr_i, ini_we_i, ini_be_i, ini_wdata_i,
        input  tgt_gnt_i, tgt_rvalid_i, tgt_rdata_i, tgt_err_i,
        output ini_gnt_o, ini_rvalid_o, ini_rdata_o, ini_err_o,
        output tgt_req_o, tgt_addr_o, tgt_we_o, tgt_be_o, tgt_wdata_o
    );

    modport master (
        output ini_req_i, ini_addr_i, ini_we_i, ini_be_i, ini_wdata_i,
        output tgt_gnt_i, tgt_rvalid_i, tgt_rdata_i, tgt_err_i,
        input  ini_gnt_o, ini_rvalid_o, ini_rdata_o, ini_err_o,
        input  tgt_req_o, tgt_addr_o, tgt_we_o, tgt_be_o, tgt_wdata_o
    );
endinterface

// File: rtl/zeroheti_addr_decode.sv
// Combinational region decoder: lowest matching rule index wins, match flag when any hits.
module zeroheti_addr_decode
    import zeroheti_pkg::*;
#(
    parameter int unsigned NumRules  = 2,
    parameter int unsigned AddrWidth = 32,
    parameter int unsigned IdxW      = 2
) (
    input  addr_rule_t [NumRules-1:0] addr_map_i,
    input  logic [AddrWidth-1:0]       addr_i,
    output logic [IdxW-1:0]            sel_o,
    output logic                       match_o
);
    always_comb begin
        sel_o   = '0;
        match_o = 1'b0;
        // Walk downwards so the lowest matching index overwrites the others.
        for (int i = int'(NumRules) - 1; i >= 0; i--) begin
            if ((addr_i >= addr_map_i[i].base) && (addr_i < addr_map_i[i].last)) begin
                sel_o   = IdxW'(i);
                match_o = 1'b1;
            end
        end
    end
endmodule

// File: rtl/zeroheti_addr_demux.sv
// In-order address demux; ZEROHETI_DEMUX_ERR_RESP_EN adds an internal error responder
// for unmapped addresses instead of falling back to port DefaultIdx.
module zeroheti_addr_demux
    import zeroheti_pkg::*;
#(
    parameter int unsigned NumRules       = 2,
    parameter int unsigned MaxOutstanding = 4,
    parameter int unsigned AddrWidth      = 32,
    parameter int unsigned DataWidth      = 32,
    parameter int unsigned DefaultIdx     = 0
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  addr_rule_t [NumRules-1:0]  addr_map_i,
    zeroheti_addr_demux_if.slave       bus
);
    localparam int unsigned IdxW = $clog2(NumRules + 1);
    localparam int unsigned CntW = $clog2(MaxOutstanding + 1);

    logic [IdxW-1:0] w_dec_sel;
    logic [IdxW-1:0] w_sel;
    logic            w_match;
    logic            w_stall;
    logic            w_sel_gnt;
    logic            w_rsp_raw;
    logic            w_hs;
    logic            w_rsp;
    logic [CntW-1:0] r_cnt;
    logic [IdxW-1:0] r_owner;

    zeroheti_addr_decode #(
        .NumRules  (NumRules),
        .AddrWidth (AddrWidth),
        .IdxW      (IdxW)
    ) u_decode (
        .addr_map_i (addr_map_i),
        .addr_i     (bus.ini_addr_i),
        .sel_o      (w_dec_sel),
        .match_o    (w_match)
    );

`ifdef ZEROHETI_DEMUX_ERR_RESP_EN
    localparam logic [IdxW-1:0] ErrIdx = IdxW'(NumRules);
    logic r_err_pend;
    assign w_sel = w_match ? w_dec_sel : ErrIdx;
`else
    assign w_sel = w_match ? w_dec_sel : IdxW'(DefaultIdx);
`endif

    // Responses must come back in order, so switching targets waits for a full drain.
    assign w_stall = (r_cnt == CntW'(MaxOutstanding)) ||
                     ((r_cnt != '0) && (w_sel != r_owner));

    always_comb begin
        w_sel_gnt        = 1'b0;
        w_rsp_raw        = 1'b0;
        bus.tgt_req_o    = '0;
        bus.ini_rdata_o  = '0;
        bus.ini_err_o    = 1'b0;
        for (int i = 0; i < int'(NumRules); i++) begin
            if (w_sel == IdxW'(i)) begin
                w_sel_gnt        = bus.tgt_gnt_i[i];
                bus.tgt_req_o[i] = bus.ini_req_i & ~w_stall;
            end
            if (r_owner == IdxW'(i)) begin
                w_rsp_raw       = bus.tgt_rvalid_i[i];
                bus.ini_rdata_o = bus.tgt_rdata_i[i];
                bus.ini_err_o   = bus.tgt_err_i[i];
            end
        end
`ifdef ZEROHETI_DEMUX_ERR_RESP_EN
        if (w_sel == ErrIdx) begin
            w_sel_gnt = bus.ini_req_i;
        end
        if (r_owner == ErrIdx) begin
            w_rsp_raw     = r_err_pend;
            bus.ini_err_o = r_err_pend;
        end
`endif
    end

    assign bus.ini_gnt_o    = w_sel_gnt & ~w_stall;
    assign bus.ini_rvalid_o = w_rsp_raw & (r_cnt != '0);
    assign w_hs             = bus.ini_req_i & bus.ini_gnt_o;
    assign w_rsp            = bus.ini_rvalid_o;

    assign bus.tgt_addr_o   = bus.ini_addr_i;
    assign bus.tgt_we_o     = bus.ini_we_i;
    assign bus.tgt_be_o     = bus.ini_be_i;
    assign bus.tgt_wdata_o  = bus.ini_wdata_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_cnt   <= '0;
            r_owner <= '0;
        end else begin
            if (w_hs && !w_rsp) begin
                r_cnt <= r_cnt + CntW'(1);
            end else if (!w_hs && w_rsp) begin
                r_cnt <= r_cnt - CntW'(1);
            end
            if (w_hs) begin
                r_owner <= w_sel;
            end
        end
    end

`ifdef ZEROHETI_DEMUX_ERR_RESP_EN
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_err_pend <= 1'b0;
        end else begin
            r_err_pend <= w_hs && (w_sel == ErrIdx);
        end
    end
`endif

endmodule

// File: tb/tb_zeroheti_addr_demux.sv
// Bench for zeroheti_addr_demux: directed scenarios plus randomized traffic vs. a transaction-level model.
module tb_zeroheti_addr_demux;
    import zeroheti_pkg::*;

    localparam int N   = 2;
    localparam int MAX = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    addr_rule_t [N-1:0] map;

    zeroheti_addr_demux_if #(.NumRules(N), .AddrWidth(32), .DataWidth(32)) bus ();

    zeroheti_addr_demux #(
        .NumRules       (N),
        .MaxOutstanding (MAX),
        .AddrWidth      (32),
        .DataWidth      (32),
        .DefaultIdx     (0)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .addr_map_i (map),
        .bus        (bus.slave)
    );

    int n_chk  = 0;
    int n_fail = 0;

    // Transaction-level model state: outstanding count, current owner, error-slave reply due.
    int m_cnt;
    int m_owner;
    bit m_err_pend;
    int e_sel;
    bit e_hs;
    bit e_rsp;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic int ref_sel(input logic [31:0] a);
        for (int i = 0; i < N; i++) begin
            if (a >= map[i].base && a < map[i].last) return i;
        end
`ifdef ZEROHETI_DEMUX_ERR_RESP_EN
        return N;
`else
        return 0;
`endif
    endfunction

    task automatic model_reset();
        m_cnt      = 0;
        m_owner    = 0;
        m_err_pend = 1'b0;
    endtask

    task automatic model_check();
        int sel;
        bit stall;
        bit tg;
        bit src;
        logic [N-1:0] exp_req;
        sel   = ref_sel(bus.ini_addr_i);
        stall = (m_cnt == MAX) || (m_cnt > 0 && sel != m_owner);
        tg    = (sel < N) ? bus.tgt_gnt_i[sel] : bus.ini_req_i;
        exp_req = '0;
        if (sel < N && bus.ini_req_i && !stall) exp_req[sel] = 1'b1;
        e_hs  = bus.ini_req_i && tg && !stall;
        src   = (m_owner < N) ? bus.tgt_rvalid_i[m_owner] : m_err_pend;
        e_rsp = (m_cnt > 0) && src;
        e_sel = sel;
        chk("gnt",     bus.ini_gnt_o,    tg && !stall);
        chk("tgt_req", bus.tgt_req_o,    exp_req);
        chk("rvalid",  bus.ini_rvalid_o, e_rsp);
        chk("bc_addr", bus.tgt_addr_o,   bus.ini_addr_i);
        chk("bc_misc", {bus.tgt_we_o, bus.tgt_be_o, bus.tgt_wdata_o},
                       {bus.ini_we_i, bus.ini_be_i, bus.ini_wdata_i});
        if (e_rsp) begin
            if (m_owner < N) begin
                chk("rdata", bus.ini_rdata_o, bus.tgt_rdata_i[m_owner]);
                chk("err",   bus.ini_err_o,   bus.tgt_err_i[m_owner]);
            end else begin
                chk("rdata_errslv", bus.ini_rdata_o, 0);
                chk("err_errslv",   bus.ini_err_o,   1);
            end
        end
    endtask

    task automatic model_update();
        m_cnt      = m_cnt + int'(e_hs) - int'(e_rsp);
        if (e_hs) m_owner = e_sel;
        m_err_pend = e_hs && (e_sel == N);
    endtask

    task automatic drive(input bit req, input logic [31:0] addr, input logic [1:0] g, input logic [1:0] rv);
        bus.ini_req_i    = req;
        bus.ini_addr_i   = addr;
        bus.ini_we_i     = 1'b0;
        bus.ini_be_i     = req ? 4'hF : 4'h0;
        bus.ini_wdata_i  = req ? (addr ^ 32'h5A5A_0000) : 32'h0;
        bus.tgt_gnt_i    = g;
        bus.tgt_rvalid_i = rv;
    endtask

    task automatic settle();
        #1;
        model_check();
    endtask

    task automatic advance();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [1:0] bnd_exp;
        map = AddrMap;
        rst = 1'b1;
        drive(0, 32'h0, 2'b00, 2'b00);
        bus.tgt_rdata_i = '0;
        bus.tgt_err_i   = '0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("rst_cnt",    dut.r_cnt,        0);
        chk("rst_owner",  dut.r_owner,      0);
        chk("rst_gnt",    bus.ini_gnt_o,    0);
        chk("rst_req",    bus.tgt_req_o,    0);
        chk("rst_rvalid", bus.ini_rvalid_o, 0);
        rst = 1'b0;
        @(negedge clk);

        // Read at 0x9004 served by target 1.
        drive(1, 32'h9004, 2'b10, 2'b00);
        settle();
        chk("t29_req", bus.tgt_req_o, 2'b10);
        chk("t29_gnt", bus.ini_gnt_o, 1);
        advance();
        drive(0, 32'h0, 2'b00, 2'b10);
        bus.tgt_rdata_i[1] = 32'hDEAD_BEEF;
        settle();
        chk("t29_rvalid", bus.ini_rvalid_o, 1);
        chk("t29_rdata",  bus.ini_rdata_o,  32'hDEAD_BEEF);
        chk("t29_err",    bus.ini_err_o,    0);
        advance();

        // Fill to MaxOutstanding with target 0 holding off its responses.
        for (int k = 0; k < 4; k++) begin
            drive(1, 32'h0010, 2'b01, 2'b00);
            settle();
            advance();
        end
        drive(1, 32'h0010, 2'b01, 2'b00);
        settle();
        chk("t30_cnt",   dut.r_cnt,     4);
        chk("t30_stall", bus.ini_gnt_o, 0);
        advance();
        drive(1, 32'h0010, 2'b01, 2'b01);
        settle();
        advance();
        drive(1, 32'h0010, 2'b01, 2'b00);
        settle();
        chk("t30_fifth", bus.ini_gnt_o, 1);
        advance();
        for (int k = 0; k < 4; k++) begin
            drive(0, 32'h0, 2'b00, 2'b01);
            settle();
            advance();
        end
        chk("t30_drained", dut.r_cnt, 0);

        // Cross-target request waits for the drain.
        drive(1, 32'h0010, 2'b01, 2'b00);
        settle();
        advance();
        drive(1, 32'h9000, 2'b11, 2'b00);
        settle();
        chk("t31_stall_gnt", bus.ini_gnt_o, 0);
        chk("t31_stall_req", bus.tgt_req_o, 2'b00);
        advance();
        drive(1, 32'h9000, 2'b11, 2'b01);
        settle();
        advance();
        drive(1, 32'h9000, 2'b11, 2'b00);
        settle();
        chk("t31_gnt", bus.ini_gnt_o, 1);
        chk("t31_req", bus.tgt_req_o, 2'b10);
        advance();
        drive(0, 32'h0, 2'b00, 2'b10);
        settle();
        advance();

        // Region edges: last address inside, first address past the end.
        drive(1, 32'h9FFF, 2'b00, 2'b00);
        settle();
        chk("bnd_in", bus.tgt_req_o, 2'b10);
        drive(1, 32'hA000, 2'b00, 2'b00);
        settle();
`ifdef ZEROHETI_DEMUX_ERR_RESP_EN
        bnd_exp = 2'b00;
`else
        bnd_exp = 2'b01;
`endif
        chk("bnd_out", bus.tgt_req_o, bnd_exp);
        drive(0, 32'h0, 2'b00, 2'b00);
        settle();
        advance();

        // Unmapped 0x5000.
`ifdef ZEROHETI_DEMUX_ERR_RESP_EN
        drive(1, 32'h5000, 2'b00, 2'b00);
        settle();
        chk("t32_gnt", bus.ini_gnt_o, 1);
        chk("t32_req", bus.tgt_req_o, 2'b00);
        advance();
        drive(0, 32'h0, 2'b00, 2'b00);
        settle();
        chk("t32_rvalid", bus.ini_rvalid_o, 1);
        chk("t32_err",    bus.ini_err_o,    1);
        chk("t32_rdata",  bus.ini_rdata_o,  0);
        advance();
`else
        drive(1, 32'h5000, 2'b01, 2'b00);
        settle();
        chk("t33_req", bus.tgt_req_o, 2'b01);
        advance();
        drive(0, 32'h0, 2'b00, 2'b01);
        settle();
        advance();
`endif

        // Idle inputs give all-zero outputs.
        drive(0, 32'h0, 2'b00, 2'b00);
        bus.tgt_rdata_i = '0;
        bus.tgt_err_i   = '0;
        settle();
        chk("idle_out", {bus.ini_gnt_o, bus.ini_rvalid_o, bus.ini_err_o, bus.ini_rdata_o, bus.tgt_req_o}, 0);
        advance();

        // Reset with two transactions in flight.
        for (int k = 0; k < 2; k++) begin
            drive(1, 32'h0010, 2'b01, 2'b00);
            settle();
            advance();
        end
        chk("t34_pre", dut.r_cnt, 2);
        drive(0, 32'h0, 2'b00, 2'b00);
        rst = 1'b1;
        #1;
        chk("t34_cnt",   dut.r_cnt,   0);
        chk("t34_owner", dut.r_owner, 0);
        model_reset();
        rst = 1'b0;
        drive(1, 32'h9000, 2'b10, 2'b00);
        settle();
        chk("t34_gnt", bus.ini_gnt_o, 1);
        advance();
        drive(0, 32'h0, 2'b00, 2'b10);
        settle();
        advance();

        // Randomized traffic checked every cycle against the model.
        for (int c = 0; c < 3000; c++) begin
            logic [31:0] a;
            logic [1:0]  rv;
            case ($urandom_range(0, 6))
                0, 1:    a = $urandom_range(0, 32'hFFF);
                2, 3:    a = 32'h9000 + $urandom_range(0, 32'hFFF);
                4:       a = 32'h5000;
                5:       a = 32'hA000;
                default: a = 32'h1000;
            endcase
            rv[0] = ($urandom_range(0, 9) < 3);
            rv[1] = ($urandom_range(0, 9) < 3);
            drive($urandom_range(0, 3) != 0, a, 2'($urandom_range(0, 3)), rv);
            bus.ini_we_i       = 1'($urandom_range(0, 1));
            bus.ini_be_i       = 4'($urandom_range(0, 15));
            bus.ini_wdata_i    = $urandom;
            bus.tgt_rdata_i[0] = $urandom;
            bus.tgt_rdata_i[1] = $urandom;
            bus.tgt_err_i      = 2'($urandom_range(0, 3));
            settle();
            advance();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
